// File: rtl/bert_buf_pkg.sv
// Shared Q/K/V buffer definitions: tile FSM states and the
// matrix-to-BRAM-word size derivations used by fetch and store paths.
package bert_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int elems_per_word(input int dw, input int nb);
    return dw / nb;
  endfunction

  function automatic int words_per_row(input int cols, input int dw,
                                       input int nb);
    return cols / elems_per_word(dw, nb);
  endfunction

  function automatic int total_words(input int rows, input int cols,
                                     input int dw, input int nb);
    return rows * words_per_row(cols, dw, nb);
  endfunction

endpackage

// File: rtl/store_addr_counter.sv
// BRAM word address counter for the store path: wraps inside
// [OFFSET, OFFSET+TOTAL-1]; i_load reloads OFFSET and beats i_inc.
// Ports: clk, rst_n, i_load, i_inc, o_addr.
module store_addr_counter #(
  parameter int AW     = 16,
  parameter int OFFSET = 0,
  parameter int TOTAL  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr
);

  localparam logic [AW-1:0] FIRST = AW'(OFFSET);
  localparam logic [AW-1:0] LAST  = AW'(OFFSET + TOTAL - 1);

  logic [AW-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= FIRST;
    end else if (i_load) begin
      r_addr <= FIRST;
    end else if (i_inc) begin
      r_addr <= (r_addr == LAST) ? FIRST : r_addr + AW'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/store_logic_gen.sv
// Stores one tile of NUM_STORES_PER_TILE stream words into BRAM port A.
// Ports: clk, rst_n, start_store, reset_addr_counter, s_valid/s_data/
// s_ready stream, bram_en/we/addr/din, store_done, busy.
// Option STORE_STALL_CNT_EN adds stall_cycles (WRITE cycles without data).
module store_logic_gen
  import bert_buf_pkg::*;
#(
  parameter int NUM_STORES_PER_TILE = 32,
  parameter int ADDR_WIDTH          = 16,
  parameter int STORE_START_OFFSET  = 0,
  parameter int ORIGINAL_COLUMNS    = 768,
  parameter int ORIGINAL_ROWS       = 512,
  parameter int NUM_BITS            = 8,
  parameter int DATA_WIDTH          = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  store_done,
  output logic                  busy
`ifdef STORE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int TOTAL_WORDS = total_words(ORIGINAL_ROWS,
    ORIGINAL_COLUMNS, DATA_WIDTH, NUM_BITS);
  localparam int WCW = (NUM_STORES_PER_TILE > 1) ?
    $clog2(NUM_STORES_PER_TILE) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_STORES_PER_TILE - 1);

  if (longint'(STORE_START_OFFSET) + longint'(TOTAL_WORDS) >
      (longint'(1) << ADDR_WIDTH)) begin : g_cfg_err
    $error("store_logic_gen: address range exceeds ADDR_WIDTH");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WCW-1:0]        r_word_cnt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [ADDR_WIDTH-1:0] w_addr_cnt;
  logic                  w_hs;
  logic                  w_start;

  assign s_ready = (r_state == WRITE);
  assign w_hs    = s_valid & s_ready;
  assign w_start = (r_state == IDLE) & start_store;

  store_addr_counter #(
    .AW    (ADDR_WIDTH),
    .OFFSET(STORE_START_OFFSET),
    .TOTAL (TOTAL_WORDS)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(reset_addr_counter),
    .i_inc (w_hs),
    .o_addr(w_addr_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_store) w_state_nxt = WRITE;
      WRITE:   if (w_hs && r_word_cnt == LAST_WORD) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
    end else if (w_hs) begin
      r_word_cnt <= r_word_cnt + WCW'(1);
    end
  end

  // Write port lags the handshake by one cycle; addr/din hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_wr <= w_hs;
      if (w_hs) begin
        r_addr <= w_addr_cnt;
        r_din  <= s_data;
      end
    end
  end

  assign bram_en    = r_wr;
  assign bram_we    = r_wr;
  assign bram_addr  = r_addr;
  assign bram_din   = r_din;
  assign store_done = (r_state == DONE);
  assign busy       = (r_state == WRITE) | (r_state == DONE);

`ifdef STORE_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_start) begin
      r_stall <= '0;
    end else if (r_state == WRITE && !s_valid && r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_store_logic_gen.sv
// Bench for store_logic_gen: tile table, random-valid reference model,
// plus reset, address-reload and small-matrix wrap sequences.
module tb_store_logic_gen;

  localparam int N   = 32;
  localparam int TW  = 512 * 768 * 8 / 256;
  localparam int OFF = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_store = 1'b0;
  logic         reset_addr_counter = 1'b0;
  logic         s_valid = 1'b0;
  logic [255:0] s_data = '0;
  logic         s_ready, bram_en, bram_we, store_done, busy;
  logic [15:0]  bram_addr;
  logic [255:0] bram_din;
`ifdef STORE_STALL_CNT_EN
  logic [15:0]  stall;
  logic [15:0]  stall2;
`endif

  logic         start2 = 1'b0;
  logic         valid2 = 1'b0;
  logic [255:0] data2 = '0;
  logic         ready2, en2, we2, done2, busy2;
  logic [15:0]  addr2;
  logic [255:0] din2;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  store_logic_gen dut (
    .clk(clk), .rst_n(rst_n), .start_store(start_store),
    .reset_addr_counter(reset_addr_counter),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .store_done(store_done), .busy(busy)
`ifdef STORE_STALL_CNT_EN
    , .stall_cycles(stall)
`endif
  );

  store_logic_gen #(
    .NUM_STORES_PER_TILE(3), .STORE_START_OFFSET(4),
    .ORIGINAL_COLUMNS(64), .ORIGINAL_ROWS(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start_store(start2),
    .reset_addr_counter(1'b0),
    .s_valid(valid2), .s_data(data2), .s_ready(ready2),
    .bram_en(en2), .bram_we(we2), .bram_addr(addr2),
    .bram_din(din2), .store_done(done2), .busy(busy2)
`ifdef STORE_STALL_CNT_EN
    , .stall_cycles(stall2)
`endif
  );

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tile phase 0=idle 1=collecting 2=done cycle.
  int           m_phase = 0;
  int           m_words = 0;
  int           m_addr  = OFF;
  logic         e_en    = 1'b0;
  logic [15:0]  e_addr  = '0;
  logic [255:0] e_din   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_words <= 0; m_addr <= OFF;
      e_en <= 1'b0; e_addr <= '0; e_din <= '0;
    end else begin
      e_en <= (m_phase == 1) && s_valid;
      if (m_phase == 1 && s_valid) begin
        e_addr <= 16'(m_addr);
        e_din  <= s_data;
      end
      if (reset_addr_counter) m_addr <= OFF;
      else if (m_phase == 1 && s_valid)
        m_addr <= OFF + (m_addr - OFF + 1) % TW;
      case (m_phase)
        0: if (start_store) begin m_phase <= 1; m_words <= 0; end
        1: if (s_valid) begin
             m_words <= m_words + 1;
             if (m_words + 1 == N) m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en", bram_en, e_en);
      chk("we", bram_we, e_en);
      chk("addr", bram_addr, e_addr);
      chk("din", bram_din, e_din);
      chk("done", store_done, m_phase == 2);
      chk("ready", s_ready, m_phase == 1);
      chk("busy", busy, m_phase != 0);
    end
  end

  int wq[$];
  int wq2[$];
  int done_cnt = 0;
  int done_cnt2 = 0;

  always @(negedge clk) begin
    if (bram_en) wq.push_back(int'(bram_addr));
    if (store_done) done_cnt++;
    if (en2) wq2.push_back(int'(addr2));
    if (done2) done_cnt2++;
  end

  // mode: 0 continuous, 1 toggle, 2 random, 3 continuous + start pulse
  task automatic run_tile(input int mode, input int rac_idx,
                          input int stop_at, output int zeros);
    int hs = 0;
    int i = 0;
    bit v;
    zeros = 0;
    wq.delete();
    done_cnt = 0;
    @(negedge clk);
    start_store = 1'b1;
    s_valid = 1'b0;
    while (hs < stop_at && i < 2000) begin
      @(negedge clk);
      start_store = (mode == 3 && i == 5);
      case (mode)
        1:       v = (i % 2 == 0);
        2:       v = 1'($urandom % 2);
        default: v = 1'b1;
      endcase
      reset_addr_counter = v && (hs == rac_idx);
      s_valid = v;
      s_data = {8{$urandom}};
      if (v) hs++;
      else zeros++;
      i++;
    end
    if (hs < stop_at) chk("tile_timeout", 256'(hs), 256'(stop_at));
    @(negedge clk);
    s_valid = 1'b0;
    start_store = 1'b0;
    reset_addr_counter = 1'b0;
  endtask

  typedef struct {
    int mode;
    int first;
    int last;
    int stall;
  } vec_t;

  vec_t vt[4];

  task automatic run_tile2();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid2 = 1'b1;
      data2 = {8{$urandom}};
      @(negedge clk);
    end
    valid2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int z;
    vt[0] = '{0, 0,  31,  0};
    vt[1] = '{1, 32, 63,  31};
    vt[2] = '{2, 64, 95,  -1};
    vt[3] = '{3, 96, 127, 0};

    #3 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("rst_en", bram_en, 1'b0);
    chk("rst_addr", bram_addr, '0);
    chk("rst_din", bram_din, '0);
    chk("rst_done", store_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      run_tile(vt[t].mode, -1, N, z);
      repeat (4) @(negedge clk);
      chk($sformatf("tile%0d_nwr", t), 256'(wq.size()), 256'(N));
      if (wq.size() == N) begin
        chk($sformatf("tile%0d_first", t), 256'(wq[0]), 256'(vt[t].first));
        chk($sformatf("tile%0d_last", t), 256'(wq[N-1]), 256'(vt[t].last));
      end
      chk($sformatf("tile%0d_done", t), 256'(done_cnt), 256'(1));
`ifdef STORE_STALL_CNT_EN
      chk($sformatf("tile%0d_stall", t), 256'(stall),
          256'(vt[t].stall < 0 ? z : vt[t].stall));
`endif
    end
    chk("idle_after", busy, 1'b0);

    // Async reset with a write in flight after the 5th word.
    run_tile(0, -1, 5, z);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", bram_en, 1'b0);
    chk("mid_rst_addr", bram_addr, '0);
    chk("mid_rst_din", bram_din, '0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(0, -1, N, z);
    repeat (4) @(negedge clk);
    chk("post_rst_first", 256'(wq.size() > 0 ? wq[0] : -1), 256'(0));
    chk("post_rst_done", 256'(done_cnt), 256'(1));

    // Address reload coincident with the 10th handshake.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(0, 9, N, z);
    repeat (4) @(negedge clk);
    chk("rac_nwr", 256'(wq.size()), 256'(N));
    if (wq.size() == N) begin
      chk("rac_w10", 256'(wq[9]), 256'(9));
      chk("rac_w11", 256'(wq[10]), 256'(0));
      chk("rac_w32", 256'(wq[31]), 256'(21));
    end
    chk("rac_done", 256'(done_cnt), 256'(1));

    // Small matrix: 4 words at offset 4, 3 words per tile.
    wq2.delete();
    done_cnt2 = 0;
    run_tile2();
    run_tile2();
    chk("w2_n", 256'(wq2.size()), 256'(6));
    if (wq2.size() == 6) begin
      chk("w2_a0", 256'(wq2[0]), 256'(4));
      chk("w2_a2", 256'(wq2[2]), 256'(6));
      chk("w2_a3", 256'(wq2[3]), 256'(7));
      chk("w2_a4", 256'(wq2[4]), 256'(4));
      chk("w2_a5", 256'(wq2[5]), 256'(5));
    end
    chk("w2_done", 256'(done_cnt2), 256'(2));

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
